// File: rtl/pwm.sv
// Purpose: 8-bit PWM generator; a free-running period counter is compared with a live duty value.
// Latency: a change on en/sample is visible on pwm_o one clock after the rising edge that samples it.
// Backpressure: none; the block free-runs whenever en is high and idles cleared when en is low.
module pwm (
    input  logic       clk,
    input  logic       n_rst,   // synchronous, active-high reset despite the name
    input  logic       en,
    input  logic [7:0] sample,
    output logic       pwm_o
);

    // Period counter; its natural 8-bit wrap gives an exact 256-cycle period.
    logic [7:0] cnt;

    // Counter and registered output.
    // Reset wins over enable.
    // Dropping en clears both, so the next enabled period restarts at cnt = 0.
    // pwm_o compares the pre-edge count with the live sample.
    // So duty 255 still dips low for one cycle, when cnt = 255.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            cnt   <= 8'd0;
            pwm_o <= 1'b0;
        end else if (!en) begin
            cnt   <= 8'd0;
            pwm_o <= 1'b0;
        end else begin
            pwm_o <= (cnt < sample);
            cnt   <= cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_pwm.sv
// Purpose: self-checking bench for pwm; directed boundary checks plus randomized stimulus against a behavioural model.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_pwm;

    logic       clk;
    logic       n_rst;
    logic       en;
    logic [7:0] sample;
    logic       pwm_o;

    int tests;
    int fails;

    // Model state.
    // k is the number of enabled edges since the last cleared state.
    // exp_o is the output the rules call for after the most recent edge.
    int   k;
    logic exp_o;

    pwm dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .en     (en),
        .sample (sample),
        .pwm_o  (pwm_o)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge.
    // The model advances using the inputs present at the edge, then the output is checked against it.
    task automatic tick;
        @(posedge clk);
        if (n_rst || !en) begin
            k     = 0;
            exp_o = 1'b0;
        end else begin
            k     = k + 1;
            exp_o = (((k - 1) % 256) < int'(sample));
        end
        #1;
        tests++;
        assert (pwm_o === exp_o)
        else begin
            fails++;
            $error("FAIL model k=%0d sample=%0d: pwm_o got %b expected %b", k, sample, pwm_o, exp_o);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Directed comparison against a literal value derived from the timing rules.
    task automatic lit(input string tag, input logic want);
        tests++;
        assert (pwm_o === want)
        else begin
            fails++;
            $error("FAIL %s: pwm_o got %b expected %b", tag, pwm_o, want);
        end
    endtask

    // Return to a cleared state: one edge with en low.
    task automatic clear;
        en = 1'b0;
        tick();
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        k      = 0;
        exp_o  = 1'b0;
        n_rst  = 1'b1;
        en     = 1'b0;
        sample = 8'd0;

        // Reset held for two edges, then released with en low.
        tick();
        lit("rst_edge1", 1'b0);
        tick();
        lit("rst_edge2", 1'b0);
        n_rst = 1'b0;
        tick();
        lit("post_release", 1'b0);

        // Duty 127.
        sample = 8'd127;
        en = 1'b1;
        run(1);   lit("s127_k1", 1'b1);
        run(126); lit("s127_k127", 1'b1);
        run(1);   lit("s127_k128", 1'b0);
        run(1);   lit("s127_k129", 1'b0);
        run(127); lit("s127_k256", 1'b0);
        run(1);   lit("s127_k257", 1'b1);

        // Duty 0: output never rises.
        clear();
        sample = 8'd0;
        en = 1'b1;
        run(1);   lit("s0_k1", 1'b0);
        run(126); lit("s0_k127", 1'b0);
        run(1);   lit("s0_k128", 1'b0);
        run(1);   lit("s0_k129", 1'b0);
        run(127); lit("s0_k256", 1'b0);
        run(1);   lit("s0_k257", 1'b0);

        // Duty 255: one low cycle per period.
        clear();
        sample = 8'd255;
        en = 1'b1;
        run(1);   lit("s255_k1", 1'b1);
        run(126); lit("s255_k127", 1'b1);
        run(1);   lit("s255_k128", 1'b1);
        run(1);   lit("s255_k129", 1'b1);
        run(126); lit("s255_k255", 1'b1);
        run(1);   lit("s255_k256", 1'b0);
        run(1);   lit("s255_k257", 1'b1);

        // Enable drop at k = 50, then re-enable from count 0.
        clear();
        sample = 8'd127;
        en = 1'b1;
        run(50);
        en = 1'b0;
        tick();   lit("endrop_low", 1'b0);
        en = 1'b1;
        tick();   lit("reen_k1", 1'b1);
        run(126); lit("reen_k127", 1'b1);
        run(1);   lit("reen_k128", 1'b0);
        run(128); lit("reen_k256", 1'b0);
        run(1);   lit("reen_k257", 1'b1);

        // Mid-period reset at k = 100 with duty 200.
        clear();
        sample = 8'd200;
        en = 1'b1;
        run(100);
        n_rst = 1'b1;
        tick();   lit("midrst_low", 1'b0);
        n_rst = 1'b0;
        tick();   lit("midrst_k1", 1'b1);
        run(198); lit("midrst_k199", 1'b1);
        run(1);   lit("midrst_k200", 1'b1);
        run(1);   lit("midrst_k201", 1'b0);

        // Live duty change mid-period takes effect at the next edge.
        clear();
        sample = 8'd10;
        en = 1'b1;
        run(20);  lit("live_k20_low", 1'b0);
        sample = 8'd100;
        tick();   lit("live_k21_high", 1'b1);

        // Randomized stimulus: duty changes, enable drops and resets, checked by the model.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 199) == 0) sample = 8'($urandom);
            if ($urandom_range(0, 3) == 0 && sample > 8'd250) sample = 8'd255;
            en    = ($urandom_range(0, 399) != 0);
            n_rst = ($urandom_range(0, 799) == 0);
            tick();
        end
        n_rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
